motion_update_broadcaster: RTL
==============================

Name: motion_update_broadcaster

Overview:
- Sending end of the motion-update broadcast bus that every per-cell double-buffered cache (position/velocity) listens on.
- On a start pulse it walks every cell in the grid and reads each cell's particle count (address 0) and then its records (addresses 1..N) through the shared 2-cycle-latency read port.
- It rebroadcasts each record with its destination cell ID, framed by motion_update_enable, so each receiver refills its alternate buffer and swaps.

Parameters:
- DATA_WIDTH, 32, width of one vector component (record is 3*DATA_WIDTH, {z,y,x}).
- ADDR_WIDTH, 8, cell memory address width.
- CELL_ID_WIDTH, 4, width of one cell coordinate.
- CELL_X_NUM, 4, cells along x (IDs 1..CELL_X_NUM).
- CELL_Y_NUM, 4, cells along y.
- CELL_Z_NUM, 4, cells along z.
- MAX_PARTICLE, 219, largest legal per-cell count (PARTICLE_NUM-1).
- RECV_GUARD, 3, idle cycles after enable drops before done (receiver write-count + swap).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- in_start  in  1  one-cycle start pulse; ignored unless idle.
- in_particle_info  in  3*DATA_WIDTH  read data, valid 2 cycles after out_rden.
- in_dst_cell  in  3*CELL_ID_WIDTH  destination {x,y,z} from the position path, aligned with in_particle_info.
- out_rd_cell_id  out  3*CELL_ID_WIDTH  source cell being read, {x,y,z}.
- out_rd_address  out  ADDR_WIDTH  read address.
- out_rden  out  1  read enable.
- out_motion_update_enable  out  1  high for the whole broadcast.
- out_data  out  3*DATA_WIDTH  broadcast record.
- out_data_dst_cell  out  3*CELL_ID_WIDTH  destination cell of out_data.
- out_data_valid  out  1  broadcast record valid.
- out_busy  out  1  high from start accept to done.
- out_done  out  1  one-cycle pulse at completion.
- out_total_count  out  16  records broadcast in the last/current pass.

Behaviour:
- **Reset (rst=0, async):**
  - All outputs 0, and out_rd_cell_id = {1,1,1}.
  - State IDLE; counters cleared.
  - Reset mid-pass aborts immediately and drops enable with no count write-back.
- **States and transitions:**
  - IDLE --in_start--> RD_CNT. On this cycle: enable=1, busy=1, total=0, cell={1,1,1}.
  - RD_CNT: one cycle, rden=1, addr=0 → WAIT_CNT.
  - WAIT_CNT: 2 cycles, rden=0. Latch count = in_particle_info[ADDR_WIDTH-1:0], saturated to MAX_PARTICLE. If count=0 → NEXT, else → STREAM.
  - STREAM: rden=1, addr=1..count, one per cycle, no bubbles → DRAIN after addr=count.
  - DRAIN: 2 cycles, rden=0, letting in-flight data return → NEXT.
  - NEXT: advance cell z fastest, then y, then x, each wrapping to 1. After ({X,Y,Z}) → GUARD, else → RD_CNT.
  - GUARD: enable=0 for RECV_GUARD cycles → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- **Data path:**
  - A 2-stage valid shift register tracks rden only for particle reads; address 0 reads are never broadcast.
  - Broadcast is registered: a read issued at cycle t gives out_data = in_particle_info(t+2) and out_data_dst_cell = in_dst_cell(t+2), with out_data_valid=1 at t+3.
  - When out_data_valid=0, out_data and out_data_dst_cell are 0.
  - out_total_count increments per valid record and saturates at 0xFFFF.
- **Enable framing:** enable is high at least 3 cycles before the first valid and stays high until 1 cycle after the last valid. This covers the receiver capturing a valid in its first enable cycle.
- in_start while busy is ignored. Data/dst inputs are don't-care when no particle read is in flight.

Test Plan:
- Grid 1x1x2, cell(1,1,1) count=3 (records A,B,C, dst 1,1,2), cell(1,1,2) count=0, start → expected response:
  - Three valid beats A,B,C with dst 0x112, back-to-back.
  - Enable high over all of them.
  - Done pulse RECV_GUARD+1 cycles after enable falls; total=3.
- Address-0 timing check, any grid → rden/addr=0 at cycle 1 after start; first particle addr=1 at cycle 4; first valid at cycle 7.
- All cells count=0 on a 2x2x2 grid → no valid ever; 8 address-0 reads in cell order (1,1,1),(1,1,2),(1,2,1)…(2,2,2); total=0; done asserted.
- Count field 250 with MAX_PARTICLE=219 → exactly 219 reads (addr 1..219) and 219 valid beats.
- Second in_start mid-pass plus a second pass after done → first is ignored, second restarts with total reset to 0.
- Assert rst=0 during STREAM → all outputs 0 asynchronously. After release a new start runs a clean full pass, and a connected receiver cache ends with matching counts.

Source files
------------

// File: rtl/motion_update_broadcaster.sv
// Sending end of the motion-update broadcast bus: walks every grid cell, reads its count and
// records through the 2-cycle read port, and rebroadcasts each record framed by enable.
module motion_update_broadcaster #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned CELL_ID_WIDTH = 4,
  parameter int unsigned CELL_X_NUM    = 4,
  parameter int unsigned CELL_Y_NUM    = 4,
  parameter int unsigned CELL_Z_NUM    = 4,
  parameter int unsigned MAX_PARTICLE  = 219,
  parameter int unsigned RECV_GUARD    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_start,
  input  logic [3*DATA_WIDTH-1:0]    in_particle_info,
  input  logic [3*CELL_ID_WIDTH-1:0] in_dst_cell,
  output logic [3*CELL_ID_WIDTH-1:0] out_rd_cell_id,
  output logic [ADDR_WIDTH-1:0]      out_rd_address,
  output logic                       out_rden,
  output logic                       out_motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]    out_data,
  output logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell,
  output logic                       out_data_valid,
  output logic                       out_busy,
  output logic                       out_done,
  output logic [15:0]                out_total_count
);

  localparam int unsigned RecW = 3 * DATA_WIDTH;
  localparam int unsigned CidW = 3 * CELL_ID_WIDTH;

  localparam logic [ADDR_WIDTH-1:0]    MaxCnt  = ADDR_WIDTH'(MAX_PARTICLE);
  localparam logic [CELL_ID_WIDTH-1:0] CellOne = CELL_ID_WIDTH'(1);
  localparam logic [CELL_ID_WIDTH-1:0] XLast   = CELL_ID_WIDTH'(CELL_X_NUM);
  localparam logic [CELL_ID_WIDTH-1:0] YLast   = CELL_ID_WIDTH'(CELL_Y_NUM);
  localparam logic [CELL_ID_WIDTH-1:0] ZLast   = CELL_ID_WIDTH'(CELL_Z_NUM);
  localparam logic [15:0]              GuardLast = (RECV_GUARD == 0) ? 16'd0 : 16'(RECV_GUARD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdCnt,
    StWaitCnt,
    StStream,
    StDrain,
    StNext,
    StGuard,
    StDone
  } state_e;

  state_e                  r_state, w_state_nxt;
  logic                    r_wait, w_wait_nxt;
  logic [ADDR_WIDTH-1:0]   r_count, w_count_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
  logic [CELL_ID_WIDTH-1:0] r_cx, r_cy, r_cz;
  logic [CELL_ID_WIDTH-1:0] w_cx_nxt, w_cy_nxt, w_cz_nxt;
  logic [15:0]             r_guard, w_guard_nxt;
  logic                    r_enable, w_enable_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_done, w_done_nxt;
  logic                    w_clr_total;

  logic [1:0]              r_vld_pipe;
  logic                    r_valid;
  logic [RecW-1:0]         r_data;
  logic [CidW-1:0]         r_dst;
  logic [15:0]             r_total;

  logic [ADDR_WIDTH-1:0]   w_raw_cnt;
  logic [ADDR_WIDTH-1:0]   w_cnt_sat;
  logic                    w_last_cell;

  assign w_raw_cnt   = in_particle_info[ADDR_WIDTH-1:0];
  assign w_cnt_sat   = (w_raw_cnt > MaxCnt) ? MaxCnt : w_raw_cnt;
  assign w_last_cell = (r_cx == XLast) && (r_cy == YLast) && (r_cz == ZLast);

  always_comb begin
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait;
    w_count_nxt  = r_count;
    w_addr_nxt   = r_addr;
    w_cx_nxt     = r_cx;
    w_cy_nxt     = r_cy;
    w_cz_nxt     = r_cz;
    w_guard_nxt  = r_guard;
    w_enable_nxt = r_enable;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_clr_total  = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (in_start) begin
          w_state_nxt  = StRdCnt;
          w_enable_nxt = 1'b1;
          w_busy_nxt   = 1'b1;
          w_clr_total  = 1'b1;
          w_cx_nxt     = CellOne;
          w_cy_nxt     = CellOne;
          w_cz_nxt     = CellOne;
        end
      end
      StRdCnt: begin
        w_state_nxt = StWaitCnt;
        w_wait_nxt  = 1'b0;
      end
      StWaitCnt: begin
        // Count read issued in StRdCnt lands on the second wait cycle.
        if (!r_wait) begin
          w_wait_nxt = 1'b1;
        end else begin
          w_count_nxt = w_cnt_sat;
          w_addr_nxt  = ADDR_WIDTH'(1);
          w_state_nxt = (w_cnt_sat == '0) ? StNext : StStream;
        end
      end
      StStream: begin
        if (r_addr == r_count) begin
          w_state_nxt = StDrain;
          w_wait_nxt  = 1'b0;
        end else begin
          w_addr_nxt = r_addr + ADDR_WIDTH'(1);
        end
      end
      StDrain: begin
        if (!r_wait) begin
          w_wait_nxt = 1'b1;
        end else begin
          w_state_nxt = StNext;
        end
      end
      StNext: begin
        if (w_last_cell) begin
          w_state_nxt  = (RECV_GUARD == 0) ? StDone : StGuard;
          w_enable_nxt = 1'b0;
          w_guard_nxt  = '0;
        end else begin
          w_state_nxt = StRdCnt;
          if (r_cz != ZLast) begin
            w_cz_nxt = r_cz + CellOne;
          end else begin
            w_cz_nxt = CellOne;
            if (r_cy != YLast) begin
              w_cy_nxt = r_cy + CellOne;
            end else begin
              w_cy_nxt = CellOne;
              w_cx_nxt = r_cx + CellOne;
            end
          end
        end
      end
      StGuard: begin
        if (r_guard == GuardLast) begin
          w_state_nxt = StDone;
        end else begin
          w_guard_nxt = r_guard + 16'd1;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_wait   <= 1'b0;
      r_count  <= '0;
      r_addr   <= '0;
      r_cx     <= CellOne;
      r_cy     <= CellOne;
      r_cz     <= CellOne;
      r_guard  <= '0;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wait   <= w_wait_nxt;
      r_count  <= w_count_nxt;
      r_addr   <= w_addr_nxt;
      r_cx     <= w_cx_nxt;
      r_cy     <= w_cy_nxt;
      r_cz     <= w_cz_nxt;
      r_guard  <= w_guard_nxt;
      r_enable <= w_enable_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Only particle reads enter the valid pipe; count reads never reach the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_pipe <= '0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_dst      <= '0;
      r_total    <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], (r_state == StStream)};
      r_valid    <= r_vld_pipe[1];
      r_data     <= r_vld_pipe[1] ? in_particle_info : '0;
      r_dst      <= r_vld_pipe[1] ? in_dst_cell : '0;
      if (w_clr_total) begin
        r_total <= '0;
      end else if (r_vld_pipe[1] && (r_total != 16'hFFFF)) begin
        r_total <= r_total + 16'd1;
      end
    end
  end

  assign out_rden                 = (r_state == StRdCnt) || (r_state == StStream);
  assign out_rd_address           = (r_state == StStream) ? r_addr : '0;
  assign out_rd_cell_id           = {r_cx, r_cy, r_cz};
  assign out_motion_update_enable = r_enable;
  assign out_data                 = r_data;
  assign out_data_dst_cell        = r_dst;
  assign out_data_valid           = r_valid;
  assign out_busy                 = r_busy;
  assign out_done                 = r_done;
  assign out_total_count          = r_total;

endmodule
